axi_rd_arbiter: RTL and testbench

- Merges the two read requesters of the 5-stage MIPS core onto one AXI3 read master:
  - instruction fetch, AXI id 0;
  - data load from MEM, AXI id 1.
- Sits between the fetch/memory stages and the AXI interconnect. Owns AR-channel arbitration, allows one outstanding read per source, and routes R beats back by rid.
- Fetch relies on this routing to tell instruction data (rid 0) from load data (rid 1).

---
 rtl/axi_rd_arbiter.sv | 139 +++++++++++++
 tb/tb_axi_rd_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-source AXI3 read arbiter: instruction fetch (INST_ID) and data load (DATA_ID).
// Optional ARB_RR_EN macro switches fixed data priority to round-robin.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned INST_ID = 0,
  parameter int unsigned DATA_ID = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_arvalid,
  output logic              inst_arready,
  input  logic [ADDR_W-1:0] inst_araddr,
  output logic              inst_rvalid,
  input  logic              inst_rready,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_arvalid,
  output logic              data_arready,
  input  logic [ADDR_W-1:0] data_araddr,
  input  logic [2:0]        data_arsize,
  output logic              data_rvalid,
  input  logic              data_rready,
  output logic [DATA_W-1:0] data_rdata,
  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arsize,
  output logic [3:0]        m_arlen,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              err_rid
);

  localparam logic [ID_W-1:0] INST_ID_V = ID_W'(INST_ID);
  localparam logic [ID_W-1:0] DATA_ID_V = ID_W'(DATA_ID);

  typedef enum logic {IDLE = 1'b0, AR_BUSY = 1'b1} state_t;

  state_t state;
  logic   out_i;
  logic   out_d;
  logic   inst_ok;
  logic   data_ok;
  logic   grant_i;
  logic   grant_d;
  logic   rid_i;
  logic   rid_d;
  logic   r_done;
  logic   ar_hs;

  assign inst_ok = inst_arvalid && !out_i;
  assign data_ok = data_arvalid && !out_d;

`ifdef ARB_RR_EN
  // last_grant: 0 = inst, 1 = data; on conflict the other source wins
  logic last_grant;

  assign grant_d = data_ok && (!inst_ok || !last_grant);
`else
  assign grant_d = data_ok;
`endif
  assign grant_i = inst_ok && !grant_d;

  assign inst_arready = (state == IDLE) && grant_i;
  assign data_arready = (state == IDLE) && grant_d;

  assign m_arlen   = 4'd0;
  assign m_arburst = 2'b01;

  // R channel is steered by rid only; unknown ids are sunk and flagged
  assign rid_i       = (m_rid == INST_ID_V);
  assign rid_d       = (m_rid == DATA_ID_V);
  assign inst_rvalid = m_rvalid && rid_i;
  assign data_rvalid = m_rvalid && rid_d;
  assign inst_rdata  = m_rdata;
  assign data_rdata  = m_rdata;
  assign m_rready    = rid_i ? inst_rready : (rid_d ? data_rready : 1'b1);

  assign r_done = m_rvalid && m_rready && m_rlast;
  assign ar_hs  = m_arvalid && m_arready;

  // AR issue FSM with registered AR payload
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      m_arvalid <= 1'b0;
      m_arid    <= '0;
      m_araddr  <= '0;
      m_arsize  <= 3'd0;
`ifdef ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            state     <= AR_BUSY;
            m_arvalid <= 1'b1;
            m_arid    <= grant_d ? DATA_ID_V : INST_ID_V;
            m_araddr  <= grant_d ? data_araddr : inst_araddr;
            m_arsize  <= grant_d ? data_arsize : 3'd2;
`ifdef ARB_RR_EN
            last_grant <= grant_d;
`endif
          end
        end
        AR_BUSY: begin
          if (m_arready) begin
            state     <= IDLE;
            m_arvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One outstanding read per source; completion and new issue may coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      out_i   <= 1'b0;
      out_d   <= 1'b0;
      err_rid <= 1'b0;
    end else begin
      if (r_done && rid_i) out_i <= 1'b0;
      if (r_done && rid_d) out_d <= 1'b0;
      if (ar_hs && (m_arid == INST_ID_V)) out_i <= 1'b1;
      if (ar_hs && (m_arid == DATA_ID_V)) out_d <= 1'b1;
      if (m_rvalid && !rid_i && !rid_d) err_rid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter; expectations follow ARB_RR_EN when defined.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_arvalid, inst_arready, inst_rvalid, inst_rready;
  logic [31:0] inst_araddr, inst_rdata;
  logic        data_arvalid, data_arready, data_rvalid, data_rready;
  logic [31:0] data_araddr, data_rdata;
  logic [2:0]  data_arsize;
  logic [3:0]  m_arid, m_rid;
  logic [31:0] m_araddr, m_rdata;
  logic [2:0]  m_arsize;
  logic [3:0]  m_arlen;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, err_rid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_arvalid(inst_arvalid), .inst_arready(inst_arready), .inst_araddr(inst_araddr),
    .inst_rvalid(inst_rvalid), .inst_rready(inst_rready), .inst_rdata(inst_rdata),
    .data_arvalid(data_arvalid), .data_arready(data_arready), .data_araddr(data_araddr),
    .data_arsize(data_arsize), .data_rvalid(data_rvalid), .data_rready(data_rready),
    .data_rdata(data_rdata),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arlen(m_arlen),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .err_rid(err_rid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Drive one R beat for the given id and let it complete
  task automatic beat(input logic [3:0] id, input logic [31:0] d);
    m_rvalid = 1'b1; m_rid = id; m_rdata = d; m_rlast = 1'b1;
    inst_rready = 1'b1; data_rready = 1'b1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    inst_arvalid = 0; inst_araddr = 0; inst_rready = 0;
    data_arvalid = 0; data_araddr = 0; data_arsize = 0; data_rready = 0;
    m_arready = 0; m_rid = 0; m_rdata = 0; m_rlast = 0; m_rvalid = 0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_arvalid", 32'(m_arvalid), 32'd0);
    chk("rst_arid", 32'(m_arid), 32'd0);
    chk("rst_araddr", m_araddr, 32'd0);
    chk("rst_arsize", 32'(m_arsize), 32'd0);
    chk("rst_err", 32'(err_rid), 32'd0);
    chk("arlen", 32'(m_arlen), 32'd0);
    chk("arburst", 32'(m_arburst), 32'd1);

    // Single fetch
    inst_arvalid = 1; inst_araddr = 32'hBFC00000;
    settle();
    chk("fetch_arready", 32'(inst_arready), 32'd1);
    chk("fetch_data_arready", 32'(data_arready), 32'd0);
    tick();
    inst_arvalid = 0; inst_araddr = 32'h0;
    chk("fetch_arvalid", 32'(m_arvalid), 32'd1);
    chk("fetch_arid", 32'(m_arid), 32'd0);
    chk("fetch_araddr", m_araddr, 32'hBFC00000);
    chk("fetch_arsize", 32'(m_arsize), 32'd2);
    m_arready = 1;
    tick();
    m_arready = 0;
    chk("fetch_arvalid_drop", 32'(m_arvalid), 32'd0);

    // Inst outstanding blocks a second fetch; a load is still accepted
    inst_arvalid = 1; inst_araddr = 32'hBFC00004;
    settle();
    chk("blk_inst_arready", 32'(inst_arready), 32'd0);
    data_arvalid = 1; data_araddr = 32'h80000010; data_arsize = 3'd0;
    settle();
    chk("blk_data_arready", 32'(data_arready), 32'd1);
    chk("blk_inst_arready2", 32'(inst_arready), 32'd0);
    tick();
    data_arvalid = 0;
    chk("load_arid", 32'(m_arid), 32'd1);
    chk("load_arsize", 32'(m_arsize), 32'd0);
    chk("load_araddr", m_araddr, 32'h80000010);
    m_arready = 1;
    tick();
    m_arready = 0;
    chk("blk_inst_arready3", 32'(inst_arready), 32'd0);

    // Out-of-order return: load first, with fetch not ready
    m_rvalid = 1; m_rid = 4'd1; m_rdata = 32'h12345678; m_rlast = 1;
    data_rready = 1; inst_rready = 0;
    settle();
    chk("ooo_data_rvalid", 32'(data_rvalid), 32'd1);
    chk("ooo_inst_rvalid", 32'(inst_rvalid), 32'd0);
    chk("ooo_data_rdata", data_rdata, 32'h12345678);
    chk("ooo_rready_d", 32'(m_rready), 32'd1);
    data_rready = 0;
    settle();
    chk("ooo_rready_bp", 32'(m_rready), 32'd0);
    data_rready = 1;
    tick();
    m_rid = 4'd0; m_rdata = 32'h3C1D0000; inst_rready = 1; data_rready = 0;
    settle();
    chk("ooo_inst_rvalid2", 32'(inst_rvalid), 32'd1);
    chk("ooo_data_rvalid2", 32'(data_rvalid), 32'd0);
    chk("ooo_inst_rdata", inst_rdata, 32'h3C1D0000);
    chk("ooo_rready_i", 32'(m_rready), 32'd1);
    chk("bubble_inst_arready", 32'(inst_arready), 32'd0);
    tick();
    m_rvalid = 0; m_rlast = 0;
    settle();
    chk("reissue_inst_arready", 32'(inst_arready), 32'd1);
    tick();
    inst_arvalid = 0; inst_araddr = 32'h0;

    // AR backpressure: payload holds steady
    for (int i = 0; i < 5; i++) begin
      chk("bp_arvalid", 32'(m_arvalid), 32'd1);
      chk("bp_araddr", m_araddr, 32'hBFC00004);
      chk("bp_arid", 32'(m_arid), 32'd0);
      tick();
    end
    m_arready = 1;
    tick();
    m_arready = 0;
    beat(4'd0, 32'h0);
    tick();

    // Conflict: data has priority (also under round-robin, last grant was inst)
    inst_arvalid = 1; inst_araddr = 32'hBFC00008;
    data_arvalid = 1; data_araddr = 32'h80001000; data_arsize = 3'd2;
    settle();
    chk("cf_data_arready", 32'(data_arready), 32'd1);
    chk("cf_inst_arready", 32'(inst_arready), 32'd0);
    tick();
    data_arvalid = 0;
    chk("cf_arid", 32'(m_arid), 32'd1);
    chk("cf_araddr", m_araddr, 32'h80001000);
    chk("cf_busy_inst", 32'(inst_arready), 32'd0);
    m_arready = 1;
    tick();
    m_arready = 0;
    chk("cf_inst_late", 32'(inst_arready), 32'd1);
    tick();
    inst_arvalid = 0;
    chk("cf_inst_arid", 32'(m_arid), 32'd0);
    chk("cf_inst_araddr", m_araddr, 32'hBFC00008);
    m_arready = 1;
    tick();
    m_arready = 0;
    beat(4'd1, 32'h0);
    beat(4'd0, 32'h0);
    tick();

    // Conflict after a data grant
    data_arvalid = 1; data_araddr = 32'h80002000;
    settle();
    chk("solo_data_arready", 32'(data_arready), 32'd1);
    tick();
    data_arvalid = 0;
    m_arready = 1;
    tick();
    m_arready = 0;
    beat(4'd1, 32'h0);
    tick();
    inst_arvalid = 1; data_arvalid = 1;
    settle();
`ifdef ARB_RR_EN
    chk("rr_inst_arready", 32'(inst_arready), 32'd1);
    chk("rr_data_arready", 32'(data_arready), 32'd0);
`else
    chk("fp_inst_arready", 32'(inst_arready), 32'd0);
    chk("fp_data_arready", 32'(data_arready), 32'd1);
`endif
    tick();
    inst_arvalid = 0; data_arvalid = 0;
    m_arready = 1;
    tick();
    m_arready = 0;
`ifdef ARB_RR_EN
    beat(4'd0, 32'h0);
`else
    beat(4'd1, 32'h0);
`endif
    tick();

    // Unknown rid is sunk and sets a sticky error
    m_rvalid = 1; m_rid = 4'd3; m_rlast = 1; inst_rready = 0; data_rready = 0;
    settle();
    chk("unk_rready", 32'(m_rready), 32'd1);
    chk("unk_inst_rvalid", 32'(inst_rvalid), 32'd0);
    chk("unk_data_rvalid", 32'(data_rvalid), 32'd0);
    tick();
    m_rvalid = 0; m_rlast = 0;
    chk("unk_err", 32'(err_rid), 32'd1);
    tick(); tick();
    chk("unk_err_sticky", 32'(err_rid), 32'd1);

    // Reset while a load is outstanding and a fetch sits in AR_BUSY
    data_arvalid = 1; data_araddr = 32'h80003000;
    tick();
    data_arvalid = 0;
    m_arready = 1;
    tick();
    m_arready = 0;
    inst_arvalid = 1; inst_araddr = 32'hBFC00100;
    tick();
    inst_arvalid = 0;
    chk("mid_arvalid", 32'(m_arvalid), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("post_rst_arvalid", 32'(m_arvalid), 32'd0);
    chk("post_rst_araddr", m_araddr, 32'd0);
    chk("post_rst_err", 32'(err_rid), 32'd0);
    data_arvalid = 1;
    settle();
    chk("post_rst_data_ok", 32'(data_arready), 32'd1);
    data_arvalid = 0; inst_arvalid = 1;
    settle();
    chk("post_rst_inst_ok", 32'(inst_arready), 32'd1);
    tick();
    inst_arvalid = 0;
    chk("post_rst_fetch", m_araddr, 32'hBFC00100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
